// File: rtl/control_pkg.sv
// control_pkg: opcodes, bus/ALU codes, register indices and sequencer states
package control_pkg;
    localparam logic [7:0] OP_LDAC   = 8'd1;
    localparam logic [7:0] OP_LDARR1 = 8'd2;
    localparam logic [7:0] OP_CLAC   = 8'd3;
    localparam logic [7:0] OP_ADDTR  = 8'd10;
    localparam logic [7:0] OP_STACI  = 8'd13;
    localparam logic [7:0] OP_MULT   = 8'd15;
    localparam logic [7:0] OP_JPNZ   = 8'd27;
    localparam logic [7:0] OP_ENDOP  = 8'd28;

    localparam logic [3:0] BUS_NONE = 4'd0;
    localparam logic [3:0] BUS_DM   = 4'd1;
    localparam logic [3:0] BUS_IM   = 4'd2;
    localparam logic [3:0] BUS_PC   = 4'd3;
    localparam logic [3:0] BUS_AR   = 4'd4;
    localparam logic [3:0] BUS_AC   = 4'd5;
    localparam logic [3:0] BUS_DR   = 4'd6;
    localparam logic [3:0] BUS_TR   = 4'd7;
    localparam logic [3:0] BUS_R1   = 4'd8;

    localparam logic [3:0] ALU_PASS = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd3;

    localparam int WE_W  = 13;
    localparam int WE_AR = 0;
    localparam int WE_PC = 1;
    localparam int WE_IR = 2;
    localparam int WE_DR = 3;
    localparam int WE_AC = 4;
    localparam int WE_TR = 5;
    localparam int WE_R1 = 6;
    localparam int WE_R2 = 7;
    localparam int WE_R3 = 8;
    localparam int WE_RP = 9;
    localparam int WE_RQ = 10;
    localparam int WE_RC = 11;
    localparam int WE_RK = 12;

    typedef enum logic [4:0] {
        FETCH1, FETCH2, FETCH3,
        LDAC_E1, LDAC_E2,
        LDARR1_E1,
        CLAC_E1,
        ADDTR_E1, ADDTR_E2,
        STACI_E1, STACI_E2, STACI_E3,
        MULT_E1,
        JPNZ_E1, JPNZ_E2,
        NOP_E1,
        HALT
    } state_t;
endpackage

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer driving datapath strobes
module control_unit
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ir,
    input  logic        z,
    output logic        end_op,
    output logic [1:0]  inc,
    output logic [3:0]  alu_mode,
    output logic [3:0]  bus_ld,
    output logic [12:0] write_en,
    output logic [2:0]  clr,
    output logic        dm_wr,
    output logic        im_wr
);
    state_t state_q, state_d;

    always_comb begin
        state_d = FETCH1;
        case (state_q)
            FETCH1:   state_d = FETCH2;
            FETCH2:   state_d = FETCH3;
            FETCH3:
                case (ir)
                    OP_LDAC:   state_d = LDAC_E1;
                    OP_LDARR1: state_d = LDARR1_E1;
                    OP_CLAC:   state_d = CLAC_E1;
                    OP_ADDTR:  state_d = ADDTR_E1;
                    OP_STACI:  state_d = STACI_E1;
                    OP_MULT:   state_d = MULT_E1;
                    OP_JPNZ:   state_d = JPNZ_E1;
                    OP_ENDOP:  state_d = HALT;
                    default:   state_d = NOP_E1;
                endcase
            LDAC_E1:  state_d = LDAC_E2;
            ADDTR_E1: state_d = ADDTR_E2;
            STACI_E1: state_d = STACI_E2;
            STACI_E2: state_d = STACI_E3;
            JPNZ_E1:  state_d = z ? FETCH1 : JPNZ_E2;
            HALT:     state_d = HALT;
            default:  state_d = FETCH1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH1;
        else        state_q <= state_d;
    end

    assign im_wr = 1'b0;

    // Outputs are forced low while reset is held, even though the state is FETCH1.
    always_comb begin
        end_op   = 1'b0;
        inc      = '0;
        alu_mode = ALU_PASS;
        bus_ld   = BUS_NONE;
        write_en = '0;
        clr      = '0;
        dm_wr    = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH1: begin
                    bus_ld = BUS_PC;
                    write_en[WE_AR] = 1'b1;
                end
                FETCH2: begin
                    bus_ld = BUS_IM;
                    write_en[WE_IR] = 1'b1;
                    inc[0] = 1'b1;
                end
                LDAC_E1: bus_ld = BUS_DM;
                LDAC_E2: begin
                    bus_ld = BUS_DM;
                    write_en[WE_AC] = 1'b1;
                end
                LDARR1_E1: begin
                    bus_ld = BUS_R1;
                    write_en[WE_AR] = 1'b1;
                end
                CLAC_E1: clr[0] = 1'b1;
                ADDTR_E1: begin
                    bus_ld = BUS_TR;
                    alu_mode = ALU_ADD;
                end
                ADDTR_E2: begin
                    alu_mode = ALU_ADD;
                    write_en[WE_AC] = 1'b1;
                end
                STACI_E1: begin
                    bus_ld = BUS_AC;
                    write_en[WE_DR] = 1'b1;
                end
                STACI_E2: begin
                    bus_ld = BUS_DR;
                    dm_wr = 1'b1;
                end
                STACI_E3: inc[1] = 1'b1;
                MULT_E1: begin
                    bus_ld = BUS_TR;
                    alu_mode = ALU_MUL;
                    write_en[WE_AC] = 1'b1;
                end
                JPNZ_E1: begin
                    bus_ld = z ? BUS_NONE : BUS_PC;
                    write_en[WE_AR] = !z;
                    inc[0] = z;
                end
                JPNZ_E2: begin
                    bus_ld = BUS_IM;
                    write_en[WE_PC] = 1'b1;
                end
                HALT: end_op = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven per-cycle vectors checked through a scoreboard queue
module tb_control_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ir = 8'd0;
    logic        z = 1'b0;
    logic        end_op, dm_wr, im_wr;
    logic [1:0]  inc;
    logic [3:0]  alu_mode, bus_ld;
    logic [12:0] write_en;
    logic [2:0]  clr;
    logic [28:0] act;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [7:0]  ir;
        logic        z;
        logic [28:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [28:0] sb[$];

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .z(z),
        .end_op(end_op), .inc(inc), .alu_mode(alu_mode), .bus_ld(bus_ld),
        .write_en(write_en), .clr(clr), .dm_wr(dm_wr), .im_wr(im_wr)
    );

    always #5 clk = ~clk;

    assign act = {end_op, inc, alu_mode, bus_ld, write_en, clr, dm_wr, im_wr};

    function automatic logic [28:0] pk(input logic [12:0] we, input logic [3:0] bus,
                                       input logic [3:0] alu, input logic [1:0] in,
                                       input logic [2:0] cl, input logic dm, input logic eo);
        return {eo, in, alu, bus, we, cl, dm, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [28:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {eo,inc,alu,bus,we,clr,dm,im}=%h want %h (we %h/%h bus %0d/%0d)",
                     name, act, exp, act[17:5], exp[17:5], act[21:18], exp[21:18]);
        end
    endtask

    task automatic add(input logic [7:0] i, input logic zz, input logic [12:0] we,
                       input logic [3:0] bus, input logic [3:0] alu, input logic [1:0] in,
                       input logic [2:0] cl, input logic dm, input logic eo);
        vecs.push_back('{ir: i, z: zz, exp: pk(we, bus, alu, in, cl, dm, eo)});
    endtask

    task automatic fetch(input logic [7:0] i, input logic zz);
        add(i, zz, 13'h001, 4'd3, 4'd0, 2'b00, 3'b000, 1'b0, 1'b0);
        add(i, zz, 13'h004, 4'd2, 4'd0, 2'b01, 3'b000, 1'b0, 1'b0);
        add(i, zz, 13'h000, 4'd0, 4'd0, 2'b00, 3'b000, 1'b0, 1'b0);
    endtask

    // Entered at posedge+1; leaves at posedge+1 after the last vector's cycle.
    task automatic run_vecs(input string name);
        for (int k = 0; k < vecs.size(); k++) begin
            ir = vecs[k].ir;
            z  = vecs[k].z;
            sb.push_back(vecs[k].exp);
            @(negedge clk);
            chk($sformatf("%s[%0d]", name, k), sb.pop_front());
            @(posedge clk);
            #1;
        end
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", '0);
        rst_n = 1'b1;

        fetch(8'd1, 1'b0);
        add(8'd1, 1'b0, 13'h000, 4'd1, 4'd0, 2'b00, 3'b000, 1'b0, 1'b0);
        add(8'd1, 1'b0, 13'h010, 4'd1, 4'd0, 2'b00, 3'b000, 1'b0, 1'b0);
        fetch(8'd10, 1'b1);
        add(8'd10, 1'b1, 13'h000, 4'd7, 4'd1, 2'b00, 3'b000, 1'b0, 1'b0);
        add(8'd10, 1'b0, 13'h010, 4'd0, 4'd1, 2'b00, 3'b000, 1'b0, 1'b0);
        fetch(8'd13, 1'b0);
        add(8'd13, 1'b0, 13'h008, 4'd5, 4'd0, 2'b00, 3'b000, 1'b0, 1'b0);
        add(8'd13, 1'b1, 13'h000, 4'd6, 4'd0, 2'b00, 3'b000, 1'b1, 1'b0);
        add(8'd13, 1'b0, 13'h000, 4'd0, 4'd0, 2'b10, 3'b000, 1'b0, 1'b0);
        fetch(8'd15, 1'b0);
        add(8'd15, 1'b0, 13'h010, 4'd7, 4'd3, 2'b00, 3'b000, 1'b0, 1'b0);
        fetch(8'd2, 1'b0);
        add(8'd2, 1'b0, 13'h001, 4'd8, 4'd0, 2'b00, 3'b000, 1'b0, 1'b0);
        fetch(8'd3, 1'b1);
        add(8'd3, 1'b1, 13'h000, 4'd0, 4'd0, 2'b00, 3'b001, 1'b0, 1'b0);
        fetch(8'd27, 1'b1);
        add(8'd27, 1'b0, 13'h001, 4'd3, 4'd0, 2'b00, 3'b000, 1'b0, 1'b0);
        add(8'd27, 1'b1, 13'h002, 4'd2, 4'd0, 2'b00, 3'b000, 1'b0, 1'b0);
        fetch(8'd27, 1'b0);
        add(8'd27, 1'b1, 13'h000, 4'd0, 4'd0, 2'b01, 3'b000, 1'b0, 1'b0);
        fetch(8'd7, 1'b0);
        add(8'd7, 1'b0, 13'h000, 4'd0, 4'd0, 2'b00, 3'b000, 1'b0, 1'b0);
        fetch(8'd28, 1'b0);
        for (int k = 0; k < 6; k++)
            add(8'(k * 5), 1'(k), 13'h000, 4'd0, 4'd0, 2'b00, 3'b000, 1'b0, 1'b1);
        run_vecs("seq");

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_in_halt", '0);
        @(posedge clk);
        #1;
        chk("reset_held", '0);
        rst_n = 1'b1;

        fetch(8'd13, 1'b0);
        add(8'd13, 1'b0, 13'h008, 4'd5, 4'd0, 2'b00, 3'b000, 1'b0, 1'b0);
        run_vecs("after_halt");
        @(negedge clk);
        chk("staci_e2", pk(13'h000, 4'd6, 4'd0, 2'b00, 3'b000, 1'b1, 1'b0));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mid_staci", '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fetch(8'd1, 1'b0);
        run_vecs("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
